// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM encoding, slave address map
// and the one-hot slave select values.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_e;

  localparam logic [31:0] SLV_MASK  = 32'hFC00_0000;
  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;

  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_S0   = 3'b001;
  localparam logic [2:0] PSEL_S1   = 3'b010;
  localparam logic [2:0] PSEL_S2   = 3'b100;

  // Decode on addr[31:26]; PSEL_NONE means the address is unmapped.
  function automatic logic [2:0] psel_decode(input logic [31:0] addr);
    logic [31:0] region;
    region = addr & SLV_MASK;
    if (region == SLV0_BASE) begin
      return PSEL_S0;
    end else if (region == SLV1_BASE) begin
      return PSEL_S1;
    end else if (region == SLV2_BASE) begin
      return PSEL_S2;
    end
    return PSEL_NONE;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// ascending with wrap.
module apb_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  int unsigned     cand;
  logic [IW-1:0]   cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand     = (32'(rr_ptr) + off) % NREQ;
      cand_idx = IW'(cand);
      if (!grant_any && req_valid[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB master port between NREQ requesters, with
// address decode, wait-state timeout and a per-transfer response pulse.
module apb_req_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    Paddr,
  output logic [DW-1:0]    Pwdata,
  output logic             Pwrite,
  output logic [2:0]       Pselx,
  output logic             Penable,
  input  logic             Pready,
  input  logic [DW-1:0]    Prdata,
  input  logic             Pslverr
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  apb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, owner_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            write_q;
  logic [2:0]      sel_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            win_write;
  logic [2:0]      win_sel;
  logic            handshake;
  logic            done;
  logic            done_err;
  logic [DW-1:0]   done_rdata;

  apb_rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign win_addr  = req_addr[grant_idx*AW +: AW];
  assign win_wdata = req_wdata[grant_idx*DW +: DW];
  assign win_write = req_write[grant_idx];
  assign win_sel   = psel_decode(win_addr[31:0]);
  assign handshake = (state_q == IDLE) && grant_any;

  // Gated by Hreset so the accept is also 0 while reset is held.
  assign req_ready = (state_q == IDLE && !Hreset) ? grant : '0;

  always_comb begin
    state_d    = state_q;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = (win_sel != PSEL_NONE) ? SETUP : DECERR;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (Pready) begin
          done       = 1'b1;
          done_err   = Pslverr;
          done_rdata = (!write_q && !Pslverr) ? Prdata : '0;
          state_d    = IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = IDLE;
        end
      end
      DECERR: begin
        done     = 1'b1;
        done_err = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      sel_q       <= PSEL_NONE;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done ? (NREQ'(1) << owner_q) : '0;
      rsp_rdata_q <= done_rdata;
      rsp_err_q   <= done_err;
      if (state_q == ACCESS && state_d == ACCESS) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
      if (handshake) begin
        owner_q  <= grant_idx;
        rr_ptr_q <= IW'((32'(grant_idx) + 1) % NREQ);
        // Unmapped transfers leave the APB bus values untouched.
        if (win_sel != PSEL_NONE) begin
          addr_q  <= win_addr;
          wdata_q <= win_wdata;
          write_q <= win_write;
          sel_q   <= win_sel;
        end
      end
    end
  end

  assign Paddr     = addr_q;
  assign Pwdata    = wdata_q;
  assign Pwrite    = write_q;
  assign Pselx     = (state_q == SETUP || state_q == ACCESS) ? sel_q : PSEL_NONE;
  assign Penable   = (state_q == ACCESS);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table plus timeout and
// mid-transfer reset sequences, responses checked through a scoreboard.
module tb_apb_req_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              Hclk;
  logic              Hreset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     Paddr;
  logic [DW-1:0]     Pwdata;
  logic              Pwrite;
  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pready;
  logic [DW-1:0]     Prdata;
  logic              Pslverr;

  apb_req_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Pwrite   (Pwrite),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pready   (Pready),
    .Prdata   (Prdata),
    .Pslverr  (Pslverr)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int          owner;
    logic [1:0]  extra;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic [2:0]  psel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [31:0] last_paddr = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Hclk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid %0b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        exp_t e;
        logic [NREQ-1:0] oh;
        e  = sb.pop_front();
        oh = NREQ'(1) << e.owner;
        chk("rsp_owner", 64'(rsp_valid), 64'(oh));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drive a request and wait (bounded) for its accept; returns handshake cycle or -1.
  task automatic request(input vec_t v, output int c);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << v.owner;
    req_valid = oh | v.extra;
    req_write[v.owner] = v.wr;
    req_addr[v.owner*AW +: AW] = v.addr;
    req_wdata[v.owner*DW +: DW] = v.wdata;
    #1;
    for (int n = 0; n < 20 && req_ready == '0; n++) begin
      @(posedge Hclk);
      #1;
    end
    chk("req_ready", 64'(req_ready), 64'(oh));
    c = (req_ready == '0) ? -1 : cyc;
  endtask

  task automatic run_vec(input vec_t v);
    int   c;
    exp_t e;
    request(v, c);
    if (c < 0) begin
      req_valid = '0;
      return;
    end
    e.owner = v.owner;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.cyc   = c + ((v.psel != 3'b000) ? 3 + v.waits : 2);
    sb.push_back(e);
    @(posedge Hclk);
    #1;
    req_valid = v.extra;
    #1;
    if (v.psel != 3'b000) begin
      chk("setup_psel", 64'(Pselx), 64'(v.psel));
      chk("setup_penable", 64'(Penable), 64'd0);
      chk("setup_paddr", 64'(Paddr), 64'(v.addr));
      chk("setup_pwdata", 64'(Pwdata), 64'(v.wdata));
      chk("setup_pwrite", 64'(Pwrite), 64'(v.wr));
      last_paddr = v.addr;
      @(posedge Hclk);
      #1;
      for (int w = 0; w <= v.waits; w++) begin
        Pready  = (w == v.waits);
        Prdata  = v.prdata;
        Pslverr = v.slverr && (w == v.waits);
        #1;
        chk("access_penable", 64'(Penable), 64'd1);
        chk("access_psel", 64'(Pselx), 64'(v.psel));
        @(posedge Hclk);
        #1;
      end
      Pready  = 1'b0;
      Prdata  = '0;
      Pslverr = 1'b0;
    end else begin
      chk("decerr_psel", 64'(Pselx), 64'd0);
      chk("decerr_penable", 64'(Penable), 64'd0);
      chk("decerr_paddr_hold", 64'(Paddr), 64'(last_paddr));
      @(posedge Hclk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_paddr"}, 64'(Paddr), 64'd0);
    chk({tag, "_pwdata"}, 64'(Pwdata), 64'd0);
    chk({tag, "_pwrite"}, 64'(Pwrite), 64'd0);
    chk({tag, "_psel"}, 64'(Pselx), 64'd0);
    chk({tag, "_penable"}, 64'(Penable), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int   c;

    //           own extra  wr    addr          wdata        prdata       w  serr  psel    err   rdata
    vecs[0] = '{0, 2'b00, 1'b1, 32'h8100_0000, 32'd45,      32'd0,       0, 1'b0, 3'b001, 1'b0, 32'd0};
    vecs[1] = '{1, 2'b00, 1'b0, 32'h8500_0010, 32'h0,       32'd543,     2, 1'b0, 3'b010, 1'b0, 32'd543};
    vecs[2] = '{0, 2'b00, 1'b0, 32'h8800_0004, 32'h1234,    32'hDEAD,    1, 1'b1, 3'b100, 1'b1, 32'd0};
    vecs[3] = '{1, 2'b00, 1'b1, 32'h9000_0000, 32'h5A5A,    32'h0,       0, 1'b0, 3'b000, 1'b1, 32'd0};
    vecs[4] = '{0, 2'b10, 1'b0, 32'h8000_0100, 32'h0,       32'h11,      0, 1'b0, 3'b001, 1'b0, 32'h11};
    vecs[5] = '{1, 2'b01, 1'b0, 32'h8400_0200, 32'h0,       32'h22,      0, 1'b0, 3'b010, 1'b0, 32'h22};
    vecs[6] = '{0, 2'b10, 1'b1, 32'h8800_0300, 32'h77,      32'h33,      0, 1'b0, 3'b100, 1'b0, 32'd0};
    vecs[7] = '{1, 2'b00, 1'b0, 32'h8000_0400, 32'h0,       32'h44,      0, 1'b0, 3'b001, 1'b0, 32'h44};

    Hreset    = 1'b1;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    Pready    = 1'b0;
    Prdata    = '0;
    Pslverr   = 1'b0;
    @(posedge Hclk);
    @(posedge Hclk);
    #1;
    chk_all_zero("reset");
    Hreset    = 1'b0;
    req_valid = '0;
    @(posedge Hclk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Timeout: Pready never rises, slave drives garbage read data.
    v = '{0, 2'b00, 1'b0, 32'h8000_0020, 32'h0, 32'h55, 0, 1'b0, 3'b001, 1'b1, 32'd0};
    request(v, c);
    if (c >= 0) begin
      e = '{0, 32'd0, 1'b1, c + TIMEOUT + 2};
      sb.push_back(e);
      @(posedge Hclk);
      #1;
      req_valid = '0;
      Prdata    = 32'h55;
      @(posedge Hclk);
      #1;
      for (int i = 0; i < TIMEOUT; i++) begin
        chk("timeout_penable", 64'(Penable), 64'd1);
        @(posedge Hclk);
        #1;
      end
      chk("timeout_penable_drop", 64'(Penable), 64'd0);
      chk("timeout_psel_drop", 64'(Pselx), 64'd0);
      Prdata = '0;
    end
    req_valid = '0;

    // Reset during ACCESS: transfer dropped, pointer back to req0.
    v = '{0, 2'b00, 1'b1, 32'h8400_0000, 32'hCAFE, 32'h0, 0, 1'b0, 3'b010, 1'b0, 32'd0};
    request(v, c);
    if (c >= 0) begin
      @(posedge Hclk);
      #1;
      req_valid = 2'b11;
      @(posedge Hclk);
      #1;
      chk("pre_reset_penable", 64'(Penable), 64'd1);
      Hreset = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(posedge Hclk);
      @(posedge Hclk);
      #1;
      Hreset    = 1'b0;
      req_valid = '0;
    end
    req_valid = '0;
    last_paddr = 32'h0;
    v = '{0, 2'b10, 1'b0, 32'h8000_0008, 32'h0, 32'h99, 0, 1'b0, 3'b001, 1'b0, 32'h99};
    run_vec(v);
    req_valid = '0;

    repeat (3) @(posedge Hclk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
